// File: rtl/atm_light_recip_select_pkg.sv
// rtl/atm_light_recip_select_pkg.sv - shared constants, select codes and FSM encoding
package atm_light_recip_select_pkg;

  localparam int DEF_A_W     = 8;
  localparam int DEF_INV_W   = 14;
  localparam int INV_SAT     = (1 << DEF_INV_W) - 1;
  localparam int ALR_LATENCY = 47;

  localparam logic [1:0] SEL_R = 2'b00;
  localparam logic [1:0] SEL_G = 2'b01;
  localparam logic [1:0] SEL_B = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CMP    = 2'b01,
    ST_DIV    = 2'b10,
    ST_COMMIT = 2'b11
  } alr_state_t;

endpackage

// File: rtl/atm_light_recip_select_div.sv
// rtl/atm_light_recip_select_div.sv - recip_div_serial: restoring divider, 2^INV_W / divisor
// The load edge already resolves the first quotient bit, so a result takes INV_W+1 edges.
module recip_div_serial
  import atm_light_recip_select_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int INV_W = DEF_INV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [A_W-1:0]   divisor,
  output logic             busy,
  output logic             q_valid,
  output logic [INV_W:0]   quotient
);

  localparam int CW = $clog2(INV_W + 1);
  localparam logic [INV_W:0] DVD_INIT = {1'b1, {INV_W{1'b0}}};

  logic [A_W-1:0] r_rem;
  logic [INV_W:0] r_dvd;
  logic [INV_W:0] r_quo;
  logic [A_W-1:0] r_d;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_q_valid;

  logic [A_W-1:0] w_rem_src;
  logic [INV_W:0] w_dvd_src;
  logic [INV_W:0] w_quo_src;
  logic [A_W-1:0] w_d_src;
  logic [A_W:0]   w_trial;
  logic           w_ge;
  logic [A_W:0]   w_rem_nxt;
  logic [INV_W:0] w_quo_nxt;

  always_comb begin
    w_rem_src = load ? '0 : r_rem;
    w_dvd_src = load ? DVD_INIT : r_dvd;
    w_quo_src = load ? '0 : r_quo;
    w_d_src   = load ? divisor : r_d;
    w_trial   = {w_rem_src, w_dvd_src[INV_W]};
    w_ge      = (w_trial >= {1'b0, w_d_src});
    w_rem_nxt = w_ge ? (w_trial - {1'b0, w_d_src}) : w_trial;
    w_quo_nxt = {w_quo_src[INV_W-1:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_dvd     <= '0;
      r_quo     <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_q_valid <= 1'b0;
    end else if (load) begin
      r_rem     <= w_rem_nxt[A_W-1:0];
      r_dvd     <= {w_dvd_src[INV_W-1:0], 1'b0};
      r_quo     <= w_quo_nxt;
      r_d       <= divisor;
      r_cnt     <= CW'(INV_W);
      r_busy    <= 1'b1;
      r_q_valid <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt[A_W-1:0];
      r_dvd <= {w_dvd_src[INV_W-1:0], 1'b0};
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy    <= 1'b0;
        r_q_valid <= 1'b1;
      end
    end else begin
      r_q_valid <= 1'b0;
    end
  end

  assign busy     = r_busy;
  assign q_valid  = r_q_valid;
  assign quotient = r_quo;

endmodule

// File: rtl/atm_light_recip_select.sv
// rtl/atm_light_recip_select.sv - per-frame atmospheric light argmin select and reciprocals
// Optional omega=15/16 output scaling: ATM_OMEGA_PRESCALE_EN.
module atm_light_recip_select
  import atm_light_recip_select_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int INV_W = DEF_INV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [A_W-1:0]   A_R,
  input  logic [A_W-1:0]   A_G,
  input  logic [A_W-1:0]   A_B,
  output logic             busy,
  output logic             done,
  output logic [1:0]       sel,
  output logic [INV_W-1:0] Inv_AR,
  output logic [INV_W-1:0] Inv_AG,
  output logic [INV_W-1:0] Inv_AB
);

  localparam logic [INV_W-1:0] SAT = {INV_W{1'b1}};

  alr_state_t       r_state;
  logic [A_W-1:0]   r_a_r, r_a_g, r_a_b;
  logic [1:0]       r_sel_pend;
  logic [1:0]       r_ch;
  logic [INV_W-1:0] r_q_r, r_q_g, r_q_b;
  logic             r_busy, r_done;
  logic [1:0]       r_sel;
  logic [INV_W-1:0] r_inv_r, r_inv_g, r_inv_b;

  logic             w_load;
  logic [1:0]       w_load_ch;
  logic [A_W-1:0]   w_load_a;
  logic [A_W-1:0]   w_cur_a;
  logic             w_div_busy;
  logic             w_q_valid;
  logic [INV_W:0]   w_quo;
  logic [INV_W-1:0] w_q_sat;
  logic [1:0]       w_argmin;
  logic [INV_W-1:0] w_c_r, w_c_g, w_c_b;

  // The next channel is loaded on the same edge that retires the current one.
  always_comb begin
    w_load_ch = (r_state == ST_CMP) ? 2'd0 : (r_ch + 2'd1);
    w_load    = (r_state == ST_CMP) || ((r_state == ST_DIV) && w_q_valid && (r_ch != 2'd2));
    case (w_load_ch)
      2'd0:    w_load_a = r_a_r;
      2'd1:    w_load_a = r_a_g;
      default: w_load_a = r_a_b;
    endcase
    case (r_ch)
      2'd0:    w_cur_a = r_a_r;
      2'd1:    w_cur_a = r_a_g;
      default: w_cur_a = r_a_b;
    endcase
    w_q_sat = ((w_cur_a == '0) || (w_quo > {1'b0, SAT})) ? SAT : w_quo[INV_W-1:0];
    if ((r_a_r <= r_a_g) && (r_a_r <= r_a_b))
      w_argmin = SEL_R;
    else if (r_a_g <= r_a_b)
      w_argmin = SEL_G;
    else
      w_argmin = SEL_B;
  end

`ifdef ATM_OMEGA_PRESCALE_EN
  assign w_c_r = r_q_r - (r_q_r >> 4);
  assign w_c_g = r_q_g - (r_q_g >> 4);
  assign w_c_b = r_q_b - (r_q_b >> 4);
`else
  assign w_c_r = r_q_r;
  assign w_c_g = r_q_g;
  assign w_c_b = r_q_b;
`endif

  recip_div_serial #(.A_W(A_W), .INV_W(INV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .divisor  (w_load_a),
    .busy     (w_div_busy),
    .q_valid  (w_q_valid),
    .quotient (w_quo)
  );

  // busy stays up through the done cycle and drops at the following IDLE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a_r      <= '0;
      r_a_g      <= '0;
      r_a_b      <= '0;
      r_sel_pend <= SEL_R;
      r_ch       <= 2'd0;
      r_q_r      <= '0;
      r_q_g      <= '0;
      r_q_b      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sel      <= SEL_R;
      r_inv_r    <= SAT;
      r_inv_g    <= SAT;
      r_inv_b    <= SAT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start && !w_div_busy) begin
            r_a_r   <= A_R;
            r_a_g   <= A_G;
            r_a_b   <= A_B;
            r_ch    <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= ST_CMP;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_CMP: begin
          r_sel_pend <= w_argmin;
          r_state    <= ST_DIV;
        end
        ST_DIV: begin
          if (w_q_valid) begin
            case (r_ch)
              2'd0: begin
                r_q_r <= w_q_sat;
                r_ch  <= 2'd1;
              end
              2'd1: begin
                r_q_g <= w_q_sat;
                r_ch  <= 2'd2;
              end
              default: begin
                r_q_b   <= w_q_sat;
                r_state <= ST_COMMIT;
              end
            endcase
          end
        end
        ST_COMMIT: begin
          r_sel   <= r_sel_pend;
          r_inv_r <= w_c_r;
          r_inv_g <= w_c_g;
          r_inv_b <= w_c_b;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign sel    = r_sel;
  assign Inv_AR = r_inv_r;
  assign Inv_AG = r_inv_g;
  assign Inv_AB = r_inv_b;

endmodule

// File: tb/tb_atm_light_recip_select.sv
// tb/tb_atm_light_recip_select.sv - scoreboard bench for atm_light_recip_select
module tb_atm_light_recip_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_r, a_g, a_b;
  logic        busy, done;
  logic [1:0]  sel;
  logic [13:0] inv_r, inv_g, inv_b;

  typedef struct {
    logic [1:0]  e_sel;
    logic [13:0] e_r, e_g, e_b;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  logic [1:0]  p_sel;
  logic [13:0] p_r, p_g, p_b;

  atm_light_recip_select dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A_R    (a_r),
    .A_G    (a_g),
    .A_B    (a_b),
    .busy   (busy),
    .done   (done),
    .sel    (sel),
    .Inv_AR (inv_r),
    .Inv_AG (inv_g),
    .Inv_AB (inv_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [13:0] om(input int qv);
`ifdef ATM_OMEGA_PRESCALE_EN
    return 14'(qv - (qv >> 4));
`else
    return 14'(qv);
`endif
  endfunction

  // Monitor: pops on every done, and checks outputs hold while a run is in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("sel", sel, e.e_sel);
          check("inv_ar", inv_r, e.e_r);
          check("inv_ag", inv_g, e.e_g);
          check("inv_ab", inv_b, e.e_b);
          check("done_latency", cyc, e.acc + 47);
        end
      end else if (busy) begin
        check("hold_sel", sel, p_sel);
        check("hold_inv", {inv_r, inv_g, inv_b}, {p_r, p_g, p_b});
      end
    end
    p_sel = sel;
    p_r   = inv_r;
    p_g   = inv_g;
    p_b   = inv_b;
  end

  task automatic start_run(input logic [7:0] ar, ag, ab, input bit push,
                           input logic [1:0] es, input int er, eg, eb);
    @(posedge clk);
    #1;
    a_r = ar; a_g = ag; a_b = ab; start = 1'b1;
    if (push) q.push_back('{es, om(er), om(eg), om(eb), cyc + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    a_r = 8'($urandom); a_g = 8'($urandom); a_b = 8'($urandom);
    @(negedge clk);
    check("busy_cycle0", busy, 1);
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check({nm, "_timeout"}, (k < 60), 1);
    if (k < 60) begin
      check({nm, "_busy_at_done"}, busy, 1);
      @(negedge clk);
      check({nm, "_busy_after"}, busy, 0);
      check({nm, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    int snap;
    rst_n = 1'b0; start = 1'b0; a_r = '0; a_g = '0; a_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", sel, 0);
    check("rst_inv", {inv_r, inv_g, inv_b}, {14'd16383, 14'd16383, 14'd16383});
    rst_n = 1'b1;

    start_run(8'd200, 8'd150, 8'd220, 1, 2'b01, 81, 109, 74);
    wait_done("nominal");
    start_run(8'd255, 8'd255, 8'd255, 1, 2'b00, 64, 64, 64);
    wait_done("equal");
    start_run(8'd200, 8'd150, 8'd100, 1, 2'b10, 81, 109, 163);
    wait_done("min_b");
    start_run(8'd30, 8'd100, 8'd30, 1, 2'b00, 546, 163, 546);
    wait_done("tie_rb");
    start_run(8'd1, 8'd0, 8'd128, 1, 2'b01, 16383, 16383, 128);
    wait_done("saturate");

    // Lockout: a second start during the run must be ignored.
    start_run(8'd90, 8'd40, 8'd40, 1, 2'b01, 182, 409, 409);
    repeat (9) @(posedge clk);
    #1;
    a_r = 8'd10; a_g = 8'd10; a_b = 8'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("lockout");
    repeat (60) @(posedge clk);
    check("lockout_done_count", n_done, 6);

    // Reset mid-run aborts with no done.
    start_run(8'd255, 8'd255, 8'd255, 0, 2'b00, 0, 0, 0);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sel", sel, 0);
    check("midrst_inv", {inv_r, inv_g, inv_b}, {14'd16383, 14'd16383, 14'd16383});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap = n_done;
    repeat (60) @(posedge clk);
    check("midrst_no_done", n_done, snap);
    start_run(8'd200, 8'd150, 8'd220, 1, 2'b01, 81, 109, 74);
    wait_done("post_reset");

    // start held high: back-to-back runs every 48 cycles.
    @(posedge clk);
    #1;
    a_r = 8'd50; a_g = 8'd60; a_b = 8'd70; start = 1'b1;
    q.push_back('{2'b00, om(327), om(273), om(234), cyc + 1});
    @(posedge clk);
    #1;
    a_r = 8'd255; a_g = 8'd255; a_b = 8'd255;
    q.push_back('{2'b00, om(64), om(64), om(64), cyc + 48});
    repeat (48) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("held");

    repeat (5) @(posedge clk);
    check("total_done", n_done, 9);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_light_recip_select.md
Name: atm_light_recip_select

Overview:
- Producer side of the transmission-estimation min-channel select interface.
- Once per frame, captures the atmospheric light estimate (A_R, A_G, A_B) and computes the argmin channel select code.
- Computes 14-bit fixed-point reciprocals Inv_A = floor(2^14 / A) with a serial restoring divider.
- Holds sel and the three Inv_A values stable for the downstream Fc / Inv_Ac channel multiplexers for the whole following frame.

Parameters:
- A_W, 8, width of atmospheric light inputs.
- INV_W, 14, width of reciprocal outputs; dividend = 2^INV_W.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request to capture A_R/A_G/A_B; honoured only in IDLE.
- A_R, input, A_W, red atmospheric light.
- A_G, input, A_W, green atmospheric light.
- A_B, input, A_W, blue atmospheric light.
- busy, output, 1, high from the start-accept edge until done.
- done, output, 1, one-cycle pulse when new outputs are committed.
- sel, output, 2, min channel code: 00=R, 01=G, 10=B; never 11.
- Inv_AR, output, INV_W, reciprocal of the captured A_R.
- Inv_AG, output, INV_W, reciprocal of the captured A_G.
- Inv_AB, output, INV_W, reciprocal of the captured A_B.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy=0, done=0, sel=00.
  - Inv_AR = Inv_AG = Inv_AB = 2^INV_W-1 (16383).
  - All internal capture and divider registers cleared.
- FSM states: IDLE, CMP, DIV, COMMIT.
  - IDLE: at a clock edge with start=1, capture A_R/A_G/A_B into internal registers, set busy=1, go to CMP.
  - CMP (1 cycle): compute argmin. Ties resolve to the lowest index (R before G before B). Store as pending sel, then go to DIV.
  - DIV: serial restoring division of 2^INV_W by each captured A.
    - Order R, G, B; INV_W+1 = 15 cycles per channel, one quotient bit per cycle.
    - 45 cycles total, then go to COMMIT.
  - COMMIT (1 cycle): copy pending sel and quotients to the output registers. done=1 for this cycle only. Go to IDLE with busy=0.
- Latency:
  - With the start-accept edge as cycle 0, done is high in cycle 47.
  - Output registers change only at the COMMIT edge.
  - A new start is accepted at the earliest at cycle 48.
- Output stability: sel and Inv_A* hold their previous values throughout CMP and DIV. Downstream never sees a partial update.
- Arithmetic and saturation:
  - Quotient q = floor(2^INV_W / A).
  - If q > 2^INV_W-1 (A=1) or A=0, the output saturates to 16383.
  - A=0 skips the division for that channel but still spends its 15 cycles, so latency stays fixed.
- start while busy is ignored: no queuing, no error flag. Input changes after the capture edge have no effect.
- start held high continuously: a new run begins at the edge after COMMIT, i.e. every 48 cycles.
- Reset mid-operation: the run is aborted, outputs return to reset values, and no done is produced.

Optional Feature:
- Macro: ATM_OMEGA_PRESCALE_EN.
- Defined: each committed reciprocal is scaled by omega = 15/16, giving Inv = q_sat - (q_sat >> 4).
  - Applied in COMMIT, after saturation; latency unchanged.
  - Saturated 16383 becomes 15360.
- Undefined: the raw saturated quotient is output.

Decomposition:
- Shared package:
  - SEL_R=2'b00, SEL_G=2'b01, SEL_B=2'b10.
  - INV_W and A_W defaults.
  - INV_SAT = 2^INV_W-1.
  - ALR_LATENCY = 47.
  - FSM state encoding.
- One sub-module, recip_div_serial: restoring divider with ports load, divisor, busy, q_valid, quotient, fixed at 15 cycles.
  - The top level instantiates it once and sequences the three channels.

Test Plan:
- Nominal: A=(200,150,220), start for 1 cycle -> done at cycle 47; sel=01, Inv_AR=81, Inv_AG=109, Inv_AB=74; busy high for cycles 0-47.
- Equal/tie: A=(255,255,255) -> sel=00, all Inv=64; ties A=(90,40,40) -> sel=01.
- Saturation/zero: A=(1,0,128) -> sel=01, Inv_AR=16383, Inv_AG=16383, Inv_AB=128, done still at cycle 47.
- Busy lockout: second start at cycle 10 with A=(10,10,10) -> ignored, only one done; outputs from the first A only; outputs held at their previous values until cycle 47.
- Reset mid-run: rst_n low at cycle 20 -> immediate busy=0, sel=00, Inv=16383, no done; a fresh start after release completes normally.
- With ATM_OMEGA_PRESCALE_EN: A=(200,150,220) -> Inv_AR=76, Inv_AG=103, Inv_AB=70; A_R=1 -> 15360.
